// File: rtl/clarvi_part_sequencer.sv
// Splits one decoded instruction into XLEN/SLICE_W slice micro-ops.
// Ports: clock/reset_n, flush, in_* accept side, out_* micro-op side, busy.
module clarvi_part_sequencer #(
  parameter  int XLEN      = 64,
  parameter  int SLICE_W   = 32,
  parameter  int PAYLOAD_W = 64,
  localparam int NPARTS    = XLEN / SLICE_W,
  localparam int PART_W    = (NPARTS > 1) ? $clog2(NPARTS) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_reverse,
  input  logic                 in_single,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [PART_W-1:0]    out_part,
  output logic                 out_first,
  output logic                 out_last,
  output logic                 busy
);

  if ((XLEN % SLICE_W) != 0 || NPARTS > 16 || NPARTS < 1)
  begin : g_bad_cfg
    $error("XLEN must be 1..16 multiples of SLICE_W");
  end

  localparam logic [PART_W-1:0] LAST_P =
    PART_W'(NPARTS - 1);

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  state_t                 state_q, state_d;
  logic [PART_W-1:0]      part_q, part_d;
  logic [PART_W-1:0]      issued_q, issued_d;
  logic [PAYLOAD_W-1:0]   payload_q, payload_d;
  logic                   rev_q, rev_d;
  logic                   single_q, single_d;

  logic                   accept;
  logic                   take;
  logic                   rev_in;
  logic [PART_W-1:0]      last_idx;

  // A single-slice instruction never walks the counter.
  assign rev_in   = in_reverse && !in_single &&
                    (NPARTS > 1);
  assign last_idx = single_q ? '0 : LAST_P;

  assign out_valid = (state_q == ISSUE);
  assign busy      = out_valid;
  assign out_first = out_valid && (issued_q == '0);
  assign out_last  = out_valid && (issued_q == last_idx);
  assign take      = out_valid && out_ready;

  // Refill on the last micro-op keeps issue gap-free.
  assign in_ready = !flush &&
    ((state_q == IDLE) || (take && out_last));
  assign accept   = in_valid && in_ready;

  assign out_payload = payload_q;
  assign out_part    = (NPARTS == 1) ? '0 : part_q;

  always_comb begin
    state_d   = state_q;
    part_d    = part_q;
    issued_d  = issued_q;
    payload_d = payload_q;
    rev_d     = rev_q;
    single_d  = single_q;
    if (flush) begin
      state_d  = IDLE;
      part_d   = '0;
      issued_d = '0;
    end else begin
      if (take) begin
        if (out_last) begin
          state_d  = IDLE;
          part_d   = '0;
          issued_d = '0;
        end else begin
          part_d   = rev_q ? part_q - 1'b1
                           : part_q + 1'b1;
          issued_d = issued_q + 1'b1;
        end
      end
      if (accept) begin
        state_d   = ISSUE;
        part_d    = rev_in ? LAST_P : '0;
        issued_d  = '0;
        payload_d = in_payload;
        rev_d     = rev_in;
        single_d  = in_single;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      part_q    <= '0;
      issued_q  <= '0;
      payload_q <= '0;
      rev_q     <= 1'b0;
      single_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      part_q    <= part_d;
      issued_q  <= issued_d;
      payload_q <= payload_d;
      rev_q     <= rev_d;
      single_q  <= single_d;
    end
  end

endmodule

// File: tb/tb_clarvi_part_sequencer.sv
// Bench for clarvi_part_sequencer: 2-slice and 4-slice instances
// driven together, checked against a transaction-level model.
module tb_clarvi_part_sequencer;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_payload;
  logic        in_reverse;
  logic        in_single;
  logic        out_ready;

  logic        ov [2];
  logic        ir [2];
  logic        fi [2];
  logic        la [2];
  logic        bs [2];
  logic [63:0] po [2];
  logic [0:0]  pt0;
  logic [1:0]  pt1;

  int n_cmp = 0;
  int n_bad = 0;

  bit          held [2];
  int          tot  [2];
  int          k    [2];
  bit          rv   [2];
  logic [63:0] pl   [2];
  int          np   [2];

  clarvi_part_sequencer u_d2 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]),
    .in_payload(in_payload), .in_reverse(in_reverse),
    .in_single(in_single), .out_valid(ov[0]),
    .out_ready(out_ready), .out_payload(po[0]),
    .out_part(pt0), .out_first(fi[0]),
    .out_last(la[0]), .busy(bs[0])
  );

  clarvi_part_sequencer #(.XLEN(128)) u_d4 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]),
    .in_payload(in_payload), .in_reverse(in_reverse),
    .in_single(in_single), .out_valid(ov[1]),
    .out_ready(out_ready), .out_payload(po[1]),
    .out_part(pt1), .out_first(fi[1]),
    .out_last(la[1]), .busy(bs[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(string tag, int i,
                     logic [63:0] obs,
                     logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s[%0d] got %0h want %0h",
             tag, i, obs, exp);
    end
  endtask

  function automatic int obs_part(int i);
    return (i == 0) ? int'(pt0) : int'(pt1);
  endfunction

  task automatic do_reset();
    reset_n  = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", i, 64'(ov[i]), 64'd0);
      chk("rst_busy", i, 64'(bs[i]), 64'd0);
      chk("rst_ready", i, 64'(ir[i]), 64'd1);
      chk("rst_first", i, 64'(fi[i]), 64'd0);
      chk("rst_last", i, 64'(la[i]), 64'd0);
      chk("rst_part", i, 64'(obs_part(i)), 64'd0);
      chk("rst_payload", i, po[i], 64'd0);
      held[i] = 1'b0;
      k[i]    = 0;
    end
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic step(bit v, logic [63:0] p,
                      bit r, bit s, bit rdy, bit fl);
    bit          e_ir [2];
    bit          n_held [2];
    int          n_tot [2];
    int          n_k [2];
    bit          n_rv [2];
    logic [63:0] n_pl [2];
    bit          e_last;
    int          e_part;
    in_valid   = v;
    in_payload = p;
    in_reverse = r;
    in_single  = s;
    out_ready  = rdy;
    flush      = fl;
    #1;
    for (int i = 0; i < 2; i++) begin
      e_last  = held[i] && (k[i] == tot[i] - 1);
      e_ir[i] = !fl && (!held[i] || (rdy && e_last));
      chk("valid", i, 64'(ov[i]), 64'(held[i]));
      chk("busy", i, 64'(bs[i]), 64'(held[i]));
      chk("in_ready", i, 64'(ir[i]), 64'(e_ir[i]));
      chk("first", i, 64'(fi[i]),
          64'(held[i] && k[i] == 0));
      chk("last", i, 64'(la[i]), 64'(e_last));
      if (held[i]) begin
        e_part = rv[i] ? np[i] - 1 - k[i] : k[i];
        chk("part", i, 64'(obs_part(i)), 64'(e_part));
        chk("payload", i, po[i], pl[i]);
      end
      n_held[i] = held[i];
      n_tot[i]  = tot[i];
      n_k[i]    = k[i];
      n_rv[i]   = rv[i];
      n_pl[i]   = pl[i];
      if (fl) begin
        n_held[i] = 1'b0;
        n_k[i]    = 0;
      end else begin
        if (held[i] && rdy) begin
          if (e_last) n_held[i] = 1'b0;
          else n_k[i] = k[i] + 1;
        end
        if (v && e_ir[i]) begin
          n_held[i] = 1'b1;
          n_tot[i]  = (s || np[i] == 1) ? 1 : np[i];
          n_k[i]    = 0;
          n_rv[i]   = r && !s;
          n_pl[i]   = p;
        end
      end
    end
    @(posedge clock);
    for (int i = 0; i < 2; i++) begin
      held[i] = n_held[i];
      tot[i]  = n_tot[i];
      k[i]    = n_k[i];
      rv[i]   = n_rv[i];
      pl[i]   = n_pl[i];
    end
    @(negedge clock);
  endtask

  initial begin
    np[0] = 2;
    np[1] = 4;
    for (int i = 0; i < 2; i++) begin
      held[i] = 1'b0;
      tot[i]  = 1;
      k[i]    = 0;
      rv[i]   = 1'b0;
      pl[i]   = '0;
    end
    in_payload = '0;
    in_reverse = 1'b0;
    in_single  = 1'b0;
    out_ready  = 1'b1;
    do_reset();

    step(1, 64'hA5, 0, 0, 1, 0);
    for (int j = 0; j < 5; j++) step(0, 0, 0, 0, 1, 0);

    step(1, 64'h1234, 1, 0, 1, 0);
    for (int j = 0; j < 5; j++) step(0, 0, 0, 0, 1, 0);

    step(1, 64'h55, 0, 0, 1, 0);
    for (int j = 0; j < 3; j++) step(0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 5; j++) step(0, 0, 0, 0, 1, 0);

    step(1, 64'h11, 0, 0, 1, 0);
    for (int j = 0; j < 4; j++) step(1, 64'h22, 1, 0, 1, 0);
    for (int j = 0; j < 3; j++) step(1, 64'h33, 0, 1, 1, 0);
    for (int j = 0; j < 5; j++) step(0, 0, 0, 0, 1, 0);

    step(1, 64'h44, 0, 0, 1, 0);
    step(1, 64'h66, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    step(1, 64'h77, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    do_reset();
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(bit'($urandom_range(0, 1)),
             {$urandom, $urandom},
             bit'($urandom_range(0, 1)),
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 15) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
